mesi_coherence_ctrl: RTL and testbench
======================================

// Module: mesi_coherence_ctrl
// PURPOSE
// Sequential, parametrised MESI controller for one L2 set per command. Accepts trace commands (valid/ready).
// Sequences bus ops one at a time with an ack handshake and samples snoop results.
// Queues L2->L1 messages in a FIFO, answers snoops and writes back per-way next state.
// Sits between L2 tag lookup (which supplies hit/way/set states) and the bus/L1 interfaces.
// PARAMETERS
// WAYS       8                  associativity; power of 2, >=2
// WAY_W      $clog2(WAYS)       way index width (derived)
// MSG_DEPTH  4                  L2->L1 message FIFO depth; >=4
// PORTS
// clk           in   1          clock
// rst           in   1          synchronous, active-high reset
// cmd_valid     in   1          command offered
// cmd_ready     out  1          IDLE and FIFO free slots >=3
// cmd           in   4          trace command code (cmd_t)
// hit           in   1          tag hit for cmd address
// hit_way       in   WAY_W      hit way (valid when hit)
// victim_way    in   WAY_W      replacement way (valid when !hit)
// set_state     in   2*WAYS     MESI state per way of addressed set; stable while busy
// bus_valid     out  1          bus op presented
// bus_op        out  2          bus_op_t: BREAD, BWRITE, BINVAL, BRWIM
// bus_ack       in   1          bus op complete this cycle
// snoop_result  in   2          others' response, sampled on bus_ack of BREAD/BRWIM
// snoop_out_vld out  1          one-cycle pulse: our snoop response valid
// snoop_out     out  2          snoop_t: HIT=0, HITM=1, NOHIT=2
// upd_valid     out  1          one-cycle pulse: write upd_state into upd_way
// upd_way       out  WAY_W      way to update
// upd_state     out  2          new MESI state (mesi_t: I,S,E,M)
// msg_valid     out  1          FIFO head valid
// msg           out  2          l2l1_t: GETLINE, SENDLINE, INVALLINE, EVICTLINE
// msg_ready     in   1          L1 accepts head
// BEHAVIOUR
// Reset: every output 0, FSM IDLE, FIFO empty, snoop/CLR counters 0. Reset mid-command aborts; no upd issued.
// FSM: IDLE -> EXEC (latch cmd, hit, ways, selected state) -> BUS* (one op per op, hold until bus_ack) -> UPD -> IDLE.
//   CLR uses CLRWALK instead of EXEC.
// Handshakes: cmd taken on cmd_valid&cmd_ready; bus_op/bus_valid held stable until bus_ack; FIFO pop on msg_valid&msg_ready.
// Min latency, no-bus command: accept -> UPD 2 cycles later. Each bus op adds >=1 cycle.
// Snoop result: snoop_result 2'b11 treated as NOHIT.
// Miss victim (READ/WRITE/L1_READ):
//   victim M: push EVICTLINE, then BWRITE.
//   victim E/S: push EVICTLINE only.
//   victim I: nothing.
// READ(0)/L1_READ(2):
//   hit: push SENDLINE; no state change, no upd.
//   miss: BREAD; HIT/HITM -> S, NOHIT -> E; push SENDLINE.
// WRITE(1):
//   hit M: no bus op. hit E: -> M, no bus op. hit S: BINVAL -> M.
//   miss: BRWIM -> M; push SENDLINE.
// SNOOP_INVAL(3): hit S -> I, push INVALLINE; all else no action.
// SNOOPED_RD(4), all -> S, pulse snoop_out:
//   M: HITM, push GETLINE, BWRITE.
//   E/S: HIT.
//   miss/I: NOHIT.
// SNOOP_WR(5): snoop_out NOHIT; no state change.
// SNOOP_RDWITM(6), all -> I, pulse snoop_out:
//   M: HITM, push GETLINE, BWRITE, push EVICTLINE.
//   E/S: HIT, push INVALLINE.
//   miss: NOHIT.
// CLR(8): walk ways 0..WAYS-1, one way per step:
//   M: push EVICTLINE + BWRITE. E/S: push EVICTLINE.
//   Each way: upd to I. A step stalls while FIFO full.
// PRINT(9), undefined codes: accepted, no outputs, back to IDLE next cycle.
// Simultaneous: cmd accept and FIFO pop same cycle allowed. Push and pop same cycle keeps count.
//   Push to a full FIFO never occurs; checked by assertion.
// STRUCTURE
// mypkg holds cmd_t, mesi_t, bus_op_t, snoop_t, l2l1_t encodings. Reuse existing names M/E/S/I, BREAD.., HIT...
// Sub-module msg_fifo (param WIDTH, DEPTH): sync FIFO with count, full, empty, free outputs.
// TESTING
// 1: READ miss, victim I, snoop NOHIT -> one BREAD; upd state E; msg SENDLINE.
// 2: WRITE miss, victim_way=3 in M -> EVICTLINE, BWRITE, BRWIM in order; upd way3 = M; SENDLINE.
// 3: SNOOPED_RD hit in M -> snoop_out=HITM; GETLINE; BWRITE; upd S.
// 4: CLR with set_state {M,S,I,E,...}, msg_ready=0 -> walk stalls at FIFO full;
//    resumes on drain; all 8 ways updated to I; one BWRITE.
// 5: WRITE hit S with bus_ack delayed 5 cycles -> bus_op BINVAL stable 5 cycles; cmd_ready 0 throughout; upd M.
// 6: rst asserted mid-BRWIM -> next cycle bus_valid=0, msg_valid=0, no upd; cmd_ready=1 after release.

Source files
------------

// File: rtl/mesi_coherence_ctrl_pkg.sv
// Shared encodings and per-command action decode for the MESI set controller.
package mesi_coherence_ctrl_pkg;

    typedef enum logic [3:0] {
        READ         = 4'd0,
        WRITE        = 4'd1,
        L1_READ      = 4'd2,
        SNOOP_INVAL  = 4'd3,
        SNOOPED_RD   = 4'd4,
        SNOOP_WR     = 4'd5,
        SNOOP_RDWITM = 4'd6,
        CLR          = 4'd8,
        PRINT        = 4'd9
    } cmd_t;

    typedef enum logic [1:0] {I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3} mesi_t;
    typedef enum logic [1:0] {BREAD = 2'd0, BWRITE = 2'd1, BINVAL = 2'd2, BRWIM = 2'd3} bus_op_t;
    typedef enum logic [1:0] {HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2} snoop_t;
    typedef enum logic [1:0] {GETLINE = 2'd0, SENDLINE = 2'd1, INVALLINE = 2'd2, EVICTLINE = 2'd3} l2l1_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXEC, ST_BUS_WB, ST_BUS_MAIN, ST_UPD, ST_CLR_WALK, ST_CLR_BUS
    } fsm_t;

    // A non-CLR command pushes at most two messages, so three free slots is safe.
    localparam int FIFO_HEADROOM = 3;

    typedef struct packed {
        logic    noop;
        logic    pre_push;
        l2l1_t   pre_msg;
        logic    snp_vld;
        snoop_t  snp_val;
        logic    wb;
        logic    main_vld;
        bus_op_t main_op;
        logic    post_push;
        l2l1_t   post_msg;
        logic    upd_en;
        logic    upd_snp;
        mesi_t   upd_st;
    } plan_t;

    function automatic plan_t decode_plan(input logic [3:0] c, input logic h, input mesi_t st);
        plan_t p;
        p = '0;
        case (c)
            READ, L1_READ: begin
                p.post_push = 1'b1;
                p.post_msg  = SENDLINE;
                if (!h) begin
                    p.pre_push = (st != I);
                    p.pre_msg  = EVICTLINE;
                    p.wb       = (st == M);
                    p.main_vld = 1'b1;
                    p.main_op  = BREAD;
                    p.upd_en   = 1'b1;
                    p.upd_snp  = 1'b1;
                end
            end
            WRITE: begin
                p.upd_en = 1'b1;
                p.upd_st = M;
                if (h) begin
                    p.main_vld = (st == S);
                    p.main_op  = BINVAL;
                end else begin
                    p.pre_push  = (st != I);
                    p.pre_msg   = EVICTLINE;
                    p.wb        = (st == M);
                    p.main_vld  = 1'b1;
                    p.main_op   = BRWIM;
                    p.post_push = 1'b1;
                    p.post_msg  = SENDLINE;
                end
            end
            SNOOP_INVAL: begin
                if (h && st == S) begin
                    p.upd_en    = 1'b1;
                    p.upd_st    = I;
                    p.post_push = 1'b1;
                    p.post_msg  = INVALLINE;
                end
            end
            SNOOPED_RD: begin
                p.snp_vld = 1'b1;
                p.snp_val = NOHIT;
                if (h && st != I) begin
                    p.snp_val  = (st == M) ? HITM : HIT;
                    p.pre_push = (st == M);
                    p.pre_msg  = GETLINE;
                    p.wb       = (st == M);
                    p.upd_en   = 1'b1;
                    p.upd_st   = S;
                end
            end
            SNOOP_WR: begin
                p.snp_vld = 1'b1;
                p.snp_val = NOHIT;
            end
            SNOOP_RDWITM: begin
                p.snp_vld = 1'b1;
                p.snp_val = NOHIT;
                if (h && st != I) begin
                    p.snp_val   = (st == M) ? HITM : HIT;
                    p.pre_push  = (st == M);
                    p.pre_msg   = GETLINE;
                    p.wb        = (st == M);
                    p.post_push = 1'b1;
                    p.post_msg  = (st == M) ? EVICTLINE : INVALLINE;
                    p.upd_en    = 1'b1;
                    p.upd_st    = I;
                end
            end
            default: p.noop = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mesi_coherence_ctrl_msg_fifo.sv
// Small synchronous show-ahead FIFO carrying L2->L1 messages.
module msg_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] free
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            assert (!(push && full));
        end
    end

    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign free     = CNT_W'(DEPTH) - count_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/mesi_coherence_ctrl.sv
// MESI controller for one L2 set per command: sequences bus ops, snoop replies,
// L2->L1 messages and per-way state updates.
module mesi_coherence_ctrl
    import mesi_coherence_ctrl_pkg::*;
#(
    parameter int WAYS      = 8,
    parameter int MSG_DEPTH = 4,
    localparam int WAY_W    = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd,
    input  logic              hit,
    input  logic [WAY_W-1:0]  hit_way,
    input  logic [WAY_W-1:0]  victim_way,
    input  logic [2*WAYS-1:0] set_state,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    input  logic              bus_ack,
    input  logic [1:0]        snoop_result,
    output logic              snoop_out_vld,
    output logic [1:0]        snoop_out,
    output logic              upd_valid,
    output logic [WAY_W-1:0]  upd_way,
    output logic [1:0]        upd_state,
    output logic              msg_valid,
    output logic [1:0]        msg,
    input  logic              msg_ready
);
    localparam int CNT_W = $clog2(MSG_DEPTH + 1);

    fsm_t             state_reg, state_next;
    logic [3:0]       cmd_reg;
    logic             hit_reg;
    logic [WAY_W-1:0] way_reg;
    mesi_t            way_state_reg;
    snoop_t           snp_reg;
    logic [WAY_W-1:0] clr_way_reg, clr_way_next;

    mesi_t            way_state [WAYS];
    mesi_t            clr_st;
    logic             clr_step;
    logic             clr_last;
    logic [WAY_W-1:0] sel_way;
    plan_t            plan;

    logic             push;
    logic [1:0]       push_data;
    logic [CNT_W-1:0] count, free;
    logic             full, empty;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_state[gi] = mesi_t'(set_state[2*gi +: 2]);
        end
    endgenerate

    assign sel_way  = hit ? hit_way : victim_way;
    assign clr_st   = way_state[clr_way_reg];
    assign clr_last = (clr_way_reg == WAY_W'(WAYS - 1));
    assign plan     = decode_plan(cmd_reg, hit_reg, way_state_reg);

    msg_fifo #(.WIDTH(2), .DEPTH(MSG_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (msg_ready),
        .pop_data  (msg),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .free      (free)
    );

    assign msg_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= '0;
            hit_reg       <= 1'b0;
            way_reg       <= '0;
            way_state_reg <= I;
            snp_reg       <= NOHIT;
            clr_way_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            clr_way_reg <= clr_way_next;
            if (state_reg == ST_IDLE && cmd_valid && cmd_ready) begin
                cmd_reg       <= cmd;
                hit_reg       <= hit;
                way_reg       <= sel_way;
                way_state_reg <= way_state[sel_way];
            end
            // An undefined snoop encoding from the bus counts as no other holder.
            if (state_reg == ST_BUS_MAIN && bus_ack)
                snp_reg <= (snoop_result == 2'b11) ? NOHIT : snoop_t'(snoop_result);
            assert ({1'b0, count} + {1'b0, free} == (CNT_W + 1)'(MSG_DEPTH));
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_way_next  = clr_way_reg;
        cmd_ready     = 1'b0;
        bus_valid     = 1'b0;
        bus_op        = 2'b00;
        snoop_out_vld = 1'b0;
        snoop_out     = 2'b00;
        upd_valid     = 1'b0;
        upd_way       = '0;
        upd_state     = 2'b00;
        push          = 1'b0;
        push_data     = 2'b00;
        clr_step      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cmd_ready = !rst && (free >= CNT_W'(FIFO_HEADROOM));
                if (cmd_valid && cmd_ready) begin
                    state_next   = (cmd == CLR) ? ST_CLR_WALK : ST_EXEC;
                    clr_way_next = '0;
                end
            end
            ST_EXEC: begin
                snoop_out_vld = plan.snp_vld;
                snoop_out     = plan.snp_val;
                push          = plan.pre_push;
                push_data     = plan.pre_msg;
                if (plan.noop)          state_next = ST_IDLE;
                else if (plan.wb)       state_next = ST_BUS_WB;
                else if (plan.main_vld) state_next = ST_BUS_MAIN;
                else                    state_next = ST_UPD;
            end
            ST_BUS_WB: begin
                bus_valid = 1'b1;
                bus_op    = BWRITE;
                if (bus_ack) state_next = plan.main_vld ? ST_BUS_MAIN : ST_UPD;
            end
            ST_BUS_MAIN: begin
                bus_valid = 1'b1;
                bus_op    = plan.main_op;
                if (bus_ack) state_next = ST_UPD;
            end
            ST_UPD: begin
                push      = plan.post_push;
                push_data = plan.post_msg;
                upd_valid = plan.upd_en;
                upd_way   = way_reg;
                if (plan.upd_snp) upd_state = (snp_reg == NOHIT) ? E : S;
                else              upd_state = plan.upd_st;
                state_next = ST_IDLE;
            end
            ST_CLR_WALK: begin
                // Valid lines need a FIFO slot for EVICTLINE; hold the walk until one frees.
                if (clr_st == I) begin
                    clr_step = 1'b1;
                end else if (!full) begin
                    push      = 1'b1;
                    push_data = EVICTLINE;
                    if (clr_st == M) state_next = ST_CLR_BUS;
                    else             clr_step   = 1'b1;
                end
            end
            ST_CLR_BUS: begin
                bus_valid = 1'b1;
                bus_op    = BWRITE;
                clr_step  = bus_ack;
            end
            default: state_next = ST_IDLE;
        endcase

        if (clr_step) begin
            upd_valid = 1'b1;
            upd_way   = clr_way_reg;
            upd_state = I;
            if (clr_last) begin
                state_next = ST_IDLE;
            end else begin
                clr_way_next = clr_way_reg + WAY_W'(1);
                state_next   = ST_CLR_WALK;
            end
        end
    end

endmodule

// File: tb/tb_mesi_coherence_ctrl.sv
// Scoreboard bench: stimulus queues expected bus/msg/upd/snoop events, a monitor checks them.
module tb_mesi_coherence_ctrl;
    import mesi_coherence_ctrl_pkg::*;

    localparam int WAYS = 8;
    localparam int WAY_W = 3;
    localparam int MSG_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd = '0;
    logic             hit = 1'b0;
    logic [WAY_W-1:0] hit_way = '0;
    logic [WAY_W-1:0] victim_way = '0;
    logic [2*WAYS-1:0] set_state = '0;
    logic             bus_valid;
    logic [1:0]       bus_op;
    logic             bus_ack = 1'b0;
    logic [1:0]       snoop_result = '0;
    logic             snoop_out_vld;
    logic [1:0]       snoop_out;
    logic             upd_valid;
    logic [WAY_W-1:0] upd_way;
    logic [1:0]       upd_state;
    logic             msg_valid;
    logic [1:0]       msg;
    logic             msg_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int bus_q[$];
    int msg_q[$];
    int upd_q[$];
    int snp_q[$];
    int ack_delay = 1;
    logic [1:0] snoop_val = 2'd2;
    int upd_seen = 0;

    mesi_coherence_ctrl #(.WAYS(WAYS), .MSG_DEPTH(MSG_DEPTH)) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd (cmd),
        .hit (hit), .hit_way (hit_way), .victim_way (victim_way), .set_state (set_state),
        .bus_valid (bus_valid), .bus_op (bus_op), .bus_ack (bus_ack), .snoop_result (snoop_result),
        .snoop_out_vld (snoop_out_vld), .snoop_out (snoop_out),
        .upd_valid (upd_valid), .upd_way (upd_way), .upd_state (upd_state),
        .msg_valid (msg_valid), .msg (msg), .msg_ready (msg_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Bus agent: acknowledge after ack_delay cycles of bus_valid.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bus_valid && !bus_ack) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    bus_ack      = 1'b1;
                    snoop_result = snoop_val;
                end
            end else begin
                bus_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every observed output event is matched against its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_valid === 1'b1 && bus_ack) begin
                if (bus_q.size() == 0) chk("bus_extra", int'(bus_op), -1);
                else chk("bus_op", int'(bus_op), bus_q.pop_front());
            end
            if (msg_valid === 1'b1 && msg_ready) begin
                if (msg_q.size() == 0) chk("msg_extra", int'(msg), -1);
                else chk("msg", int'(msg), msg_q.pop_front());
            end
            if (upd_valid === 1'b1) begin
                upd_seen++;
                if (upd_q.size() == 0) chk("upd_extra", int'(upd_way) * 4 + int'(upd_state), -1);
                else chk("upd_way_state", int'(upd_way) * 4 + int'(upd_state), upd_q.pop_front());
            end
            if (snoop_out_vld === 1'b1) begin
                if (snp_q.size() == 0) chk("snoop_extra", int'(snoop_out), -1);
                else chk("snoop_out", int'(snoop_out), snp_q.pop_front());
            end
        end
    end

    task automatic set_way(input int w, input mesi_t st);
        set_state[2*w +: 2] = st;
    endtask

    task automatic send(input logic [3:0] c, input logic h, input logic [2:0] hw, input logic [2:0] vw);
        int n;
        n = 0;
        cmd = c; hit = h; hit_way = hw; victim_way = vw; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        $display("cmd %0d hit=%0d hit_way=%0d victim=%0d issued", c, h, hw, vw);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bus_q.size() + msg_q.size() + upd_q.size() + snp_q.size()) != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", bus_q.size() + msg_q.size() + upd_q.size() + snp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stable;
        int base;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_bus_valid", int'(bus_valid), 0);
        chk("rst_msg_valid", int'(msg_valid), 0);
        chk("rst_upd_valid", int'(upd_valid), 0);
        chk("rst_snoop_vld", int'(snoop_out_vld), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(cmd_ready), 1);
        @(posedge clk); #1;

        // READ miss, victim I, NOHIT -> BREAD, SENDLINE, way2 E
        set_state = '0; snoop_val = 2'd2;
        bus_q.push_back(int'(BREAD)); msg_q.push_back(int'(SENDLINE)); upd_q.push_back(2*4 + int'(E));
        send(READ, 1'b0, 3'd0, 3'd2);
        drain();

        // READ miss, victim E, HITM -> EVICTLINE, BREAD, SENDLINE, way5 S
        set_state = '0; set_way(5, E); snoop_val = 2'd1;
        msg_q.push_back(int'(EVICTLINE)); bus_q.push_back(int'(BREAD)); msg_q.push_back(int'(SENDLINE));
        upd_q.push_back(5*4 + int'(S));
        send(READ, 1'b0, 3'd0, 3'd5);
        drain();

        // L1_READ hit -> SENDLINE only
        set_state = '0; set_way(1, E);
        msg_q.push_back(int'(SENDLINE));
        send(L1_READ, 1'b1, 3'd1, 3'd0);
        drain();

        // L1_READ miss, snoop 2'b11 -> treated as NOHIT, way7 E
        set_state = '0; snoop_val = 2'd3;
        bus_q.push_back(int'(BREAD)); msg_q.push_back(int'(SENDLINE)); upd_q.push_back(7*4 + int'(E));
        send(L1_READ, 1'b0, 3'd0, 3'd7);
        drain();

        // WRITE miss, victim way3 M -> EVICTLINE, BWRITE, BRWIM, SENDLINE, way3 M
        set_state = '0; set_way(3, M); snoop_val = 2'd2;
        msg_q.push_back(int'(EVICTLINE)); bus_q.push_back(int'(BWRITE)); bus_q.push_back(int'(BRWIM));
        msg_q.push_back(int'(SENDLINE)); upd_q.push_back(3*4 + int'(M));
        send(WRITE, 1'b0, 3'd0, 3'd3);
        drain();

        // SNOOPED_RD hit M -> HITM, GETLINE, BWRITE, way6 S
        set_state = '0; set_way(6, M);
        snp_q.push_back(int'(HITM)); msg_q.push_back(int'(GETLINE)); bus_q.push_back(int'(BWRITE));
        upd_q.push_back(6*4 + int'(S));
        send(SNOOPED_RD, 1'b1, 3'd6, 3'd0);
        drain();

        // SNOOPED_RD miss -> NOHIT only
        set_state = '0;
        snp_q.push_back(int'(NOHIT));
        send(SNOOPED_RD, 1'b0, 3'd0, 3'd0);
        drain();

        // SNOOP_RDWITM hit E -> HIT, INVALLINE, way0 I
        set_state = '0; set_way(0, E);
        snp_q.push_back(int'(HIT)); msg_q.push_back(int'(INVALLINE)); upd_q.push_back(0*4 + int'(I));
        send(SNOOP_RDWITM, 1'b1, 3'd0, 3'd0);
        drain();

        // SNOOP_WR -> NOHIT, nothing else
        snp_q.push_back(int'(NOHIT));
        send(SNOOP_WR, 1'b1, 3'd0, 3'd0);
        drain();

        // SNOOP_INVAL hit S -> way4 I, INVALLINE; upd two cycles after accept
        set_state = '0; set_way(4, S);
        upd_q.push_back(4*4 + int'(I)); msg_q.push_back(int'(INVALLINE));
        send(SNOOP_INVAL, 1'b1, 3'd4, 3'd0);
        @(negedge clk);
        chk("lat_exec_no_upd", int'(upd_valid), 0);
        @(negedge clk);
        chk("lat_upd", int'(upd_valid), 1);
        @(posedge clk); #1;
        drain();

        // PRINT and an undefined code: no outputs at all
        send(PRINT, 1'b1, 3'd0, 3'd0);
        send(4'd7, 1'b1, 3'd0, 3'd0);
        drain();

        // CLR with msg_ready low: stalls at way5 once the FIFO holds four EVICTLINEs
        set_state = '0;
        set_way(0, M); set_way(1, S); set_way(2, I); set_way(3, E);
        set_way(4, S); set_way(5, E); set_way(6, I); set_way(7, I);
        msg_ready = 1'b0;
        repeat (5) msg_q.push_back(int'(EVICTLINE));
        bus_q.push_back(int'(BWRITE));
        for (int w = 0; w < WAYS; w++) upd_q.push_back(w*4 + int'(I));
        base = upd_seen;
        send(CLR, 1'b0, 3'd0, 3'd0);
        repeat (20) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("clr_stall_upds", upd_seen - base, 5);
        chk("clr_stall_ready", int'(cmd_ready), 0);
        chk("clr_stall_msg_valid", int'(msg_valid), 1);
        @(posedge clk); #1;
        msg_ready = 1'b1;
        drain();
        chk("clr_total_upds", upd_seen - base, 8);

        // WRITE hit S with slow ack: BINVAL held 5 cycles, cmd_ready low, way2 M
        set_state = '0; set_way(2, S); ack_delay = 5;
        bus_q.push_back(int'(BINVAL)); upd_q.push_back(2*4 + int'(M));
        send(WRITE, 1'b1, 3'd2, 3'd0);
        n = 0; stable = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_valid) begin
                n++;
                if (bus_op != 2'(BINVAL) || cmd_ready) stable = 0;
            end
        end
        chk("binval_cycles", n, 5);
        chk("binval_stable", stable, 1);
        @(posedge clk); #1;
        ack_delay = 1;
        drain();

        // Reset during BRWIM: bus, FIFO and update all cleared, no upd issued
        set_state = '0; set_way(1, E); ack_delay = 1000; msg_ready = 1'b0;
        send(WRITE, 1'b0, 3'd0, 3'd1);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_rst_bus_valid", int'(bus_valid), 1);
        chk("pre_rst_bus_op", int'(bus_op), int'(BRWIM));
        chk("pre_rst_msg_valid", int'(msg_valid), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_bus_valid", int'(bus_valid), 0);
        chk("mid_rst_msg_valid", int'(msg_valid), 0);
        chk("mid_rst_upd_valid", int'(upd_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0; ack_delay = 1; msg_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
